wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, mul/div).
// - Uses a valid/ready handshake per source and registers the winning write onto the port (1-cycle latency).
// - Sits between the execute/memory stages and the register-file write-enable decoder.
// - Drops writes to x0 at this point so the register file never sees them.
// PARAMETERS
// - NUM_REQ  3   number of writeback requesters (2..8)
// - DATA_W   32  write data width
// - ADDR_W   5   destination register index width
// PORTS
// - clk        in   1               single clock, rising edge
// - rst        in   1               synchronous, active-high reset
// - req_valid  in   NUM_REQ         requester i has a pending write
// - req_ready  out  NUM_REQ         one-hot grant; transfer when valid&ready
// - req_rd     in   NUM_REQ*ADDR_W  packed dest index, slice i = requester i
// - req_data   in   NUM_REQ*DATA_W  packed write data, slice i = requester i
// - wr_stall   in   1               write port busy; hold output, grant nothing
// - wr_en      out  1               registered write enable to register file
// - wr_reg     out  ADDR_W          registered destination index
// - wr_data    out  DATA_W          registered write data
// - busy       out  1               |req_valid (any write pending)
// BEHAVIOUR
// - Reset: wr_en=0, wr_reg=0, wr_data=0, req_ready=0 (comb, gated by rst), priority pointer=0.
// - Grant (comb):
//   - if wr_stall|rst: req_ready=0
//   - else exactly one ready bit is set, for the highest-priority valid requester; none if no valid.
// - Requester rules:
//   - holds valid/rd/data stable until its ready is seen
//   - must not make valid depend on ready
//   - a transfer completes in the cycle valid&ready=1
// - Output register (next edge after a transfer):
//   - wr_en <= (rd!=0); wr_reg <= rd; wr_data <= data
//   - a transfer with rd==0 is accepted (ready=1) and consumed, but wr_en<=0
// - No transfer and !wr_stall: wr_en<=0; wr_reg and wr_data hold.
// - wr_stall=1: wr_en, wr_reg and wr_data all hold; no grant that cycle.
// - Throughput: one write per cycle when not stalled. Latency from grant to wr_en is 1 cycle.
// - Ordering: per-requester order is preserved. No ordering across requesters; same-rd hazards are resolved upstream.
// - Reset mid-operation: a pending write in the output register is lost; wr_en=0 on the cycle after rst.
// - Arbitration without macro: fixed priority, index 0 highest.
// CONFIGURATION
// - `WB_ARB_RR_EN` defined:
//   - round-robin priority; search starts at ptr
//   - after a transfer by requester g, ptr <= (g+1)%NUM_REQ
//   - ptr holds when there is no transfer or wr_stall=1
//   - no requester waits more than NUM_REQ-1 grants
// - `WB_ARB_RR_EN` undefined: fixed priority as above; ptr register is not built.
// STRUCTURE
// - Package wb_arb_pkg:
//   - localparams: REG_ZERO=5'd0, default DATA_W/ADDR_W/NUM_REQ
//   - function onehot_to_idx
// - Sub-module wb_prio_pick:
//   - combinational; inputs valid vector + start pointer; outputs one-hot grant
//   - start pointer tied to 0 when RR is off
// - Top level holds the output register, the optional ptr and the x0 filter.
// TESTING
// - Reset: rst=1 for 2 cycles with all valid=1 -> req_ready=0, wr_en=0, wr_reg=0, wr_data=0.
// - Single write: req0 valid, rd=5, data=32'hDEADBEEF -> ready0 same cycle; next cycle wr_en=1, wr_reg=5, data=DEADBEEF.
// - x0 drop: req1 valid, rd=0, data=32'h1234 -> ready1=1; next cycle wr_en=0.
// - Contention: req0 (rd=1) and req2 (rd=3) held valid, no macro -> grants 0 then 2; wr_reg 1 then 3 on consecutive cycles.
// - Stall: wr_stall=1 for 3 cycles with req1 valid -> ready=0 all 3 cycles; wr_* held; grant on the 4th cycle.
// - RR (`WB_ARB_RR_EN`): all 3 valid for 6 transfers -> grant order 0,1,2,0,1,2; ptr unchanged during stall cycles.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
// Contents: x0 register index, default parameter values and a one-hot to
// index helper. The helper accepts up to MAX_REQ requesters.
package wb_arb_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         DEF_NUM_REQ = 3;
  localparam int         DEF_DATA_W  = 32;
  localparam int         DEF_ADDR_W  = 5;
  localparam int         MAX_REQ     = 8;

  // Index of the set bit in a one-hot vector (0 if none is set).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// Signals: per-requester valid/ready/rd/data (packed, slice i = requester i),
// wr_stall from the port, registered wr_en/wr_reg/wr_data to the register
// file, and busy (any write pending).
// Modports: master = requester/port side, slave = arbiter side.
interface wb_port_arbiter_if import wb_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      wr_stall;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_reg;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;

  modport master (
    output req_valid, req_rd, req_data, wr_stall,
    input  req_ready, wr_en, wr_reg, wr_data, busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, wr_stall,
    output req_ready, wr_en, wr_reg, wr_data, busy
  );

endinterface

// File: rtl/wb_prio_pick.sv
// Combinational priority picker.
// Ports: valid (request vector), start (index with highest priority),
// grant (one-hot, lowest rank valid requester; zero when nothing is valid).
// Rank of requester j is its circular distance from start.
module wb_prio_pick import wb_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         start,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned N = NUM_REQ;

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned rank = 0; rank < N; rank++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && valid[j] && (((j + N - 32'(start)) % N) == rank)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources.
// Ports: clk, rst (synchronous, active high), bus (slave modport of
// wb_port_arbiter_if). The winning write is registered onto wr_* one cycle
// after its valid&ready transfer; writes to x0 are consumed without wr_en.
// Define WB_ARB_RR_EN for round-robin priority; default is fixed priority
// with requester 0 highest.
module wb_port_arbiter import wb_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] grant;
  logic [2:0]         start;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;

`ifdef WB_ARB_RR_EN
  logic [2:0] ptr;
  logic [2:0] sel;

  assign sel   = onehot_to_idx(MAX_REQ'(grant));
  assign start = ptr;

  // Pointer only advances on an actual transfer, which already excludes
  // stall and reset cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      if (32'(sel) == NUM_REQ - 1) ptr <= '0;
      else                         ptr <= sel + 3'd1;
    end
  end
`else
  assign start = '0;
`endif

  wb_prio_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid (bus.req_valid),
    .start (start),
    .grant (grant)
  );

  always_comb begin
    bus.req_ready = (rst || bus.wr_stall) ? '0 : grant;
    bus.busy      = |bus.req_valid;
    xfer          = |bus.req_ready;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) begin
        sel_rd   = bus.req_rd[j*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_reg  <= '0;
      bus.wr_data <= '0;
    end else if (!bus.wr_stall) begin
      bus.wr_en <= xfer && (sel_rd != ADDR_W'(REG_ZERO));
      if (xfer) begin
        bus.wr_reg  <= sel_rd;
        bus.wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  wb_port_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

  wb_port_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
    bus.req_rd[i*5 +: 5]    = rd;
    bus.req_data[i*32 +: 32] = data;
  endtask

  initial begin
    logic [2:0] exp_g;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.wr_stall  = 1'b0;
    bus.req_valid = 3'b111;
    set_req(0, 5'd9, 32'h11);
    set_req(1, 5'd9, 32'h22);
    set_req(2, 5'd9, 32'h33);
    #1;
    chk("rst_ready_comb", 32'(bus.req_ready), 32'h0);
    tick();
    chk("rst_ready_c1", 32'(bus.req_ready), 32'h0);
    chk("rst_wr_en_c1", 32'(bus.wr_en), 32'h0);
    tick();
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_wr_reg", 32'(bus.wr_reg), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;
    bus.req_valid = 3'b000;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // single write from requester 0
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b000;
    chk("single_wr_en", 32'(bus.wr_en), 32'h1);
    chk("single_wr_reg", 32'(bus.wr_reg), 32'h5);
    chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);

    // write to x0 from requester 1
    bus.req_valid = 3'b010;
    set_req(1, 5'd0, 32'h1234);
    #1;
    chk("x0_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 3'b000;
    chk("x0_wr_en", 32'(bus.wr_en), 32'h0);
    chk("x0_wr_reg", 32'(bus.wr_reg), 32'h0);
    chk("x0_wr_data", bus.wr_data, 32'h1234);

    // idle cycle: wr_en drops, data holds
    tick();
    chk("hold_wr_en", 32'(bus.wr_en), 32'h0);
    chk("hold_wr_data", bus.wr_data, 32'h1234);

    // contention between requesters 0 and 2
    bus.req_valid = 3'b101;
    set_req(0, 5'd1, 32'hA1);
    set_req(2, 5'd3, 32'hC3);
    #1;
`ifdef WB_ARB_RR_EN
    chk("cont_ready_a", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 3'b001;
    chk("cont_reg_a", 32'(bus.wr_reg), 32'h3);
    chk("cont_en_a", 32'(bus.wr_en), 32'h1);
    #1;
    chk("cont_ready_b", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b000;
    chk("cont_reg_b", 32'(bus.wr_reg), 32'h1);
    chk("cont_data_b", bus.wr_data, 32'hA1);
`else
    chk("cont_ready_a", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 3'b100;
    chk("cont_reg_a", 32'(bus.wr_reg), 32'h1);
    chk("cont_en_a", 32'(bus.wr_en), 32'h1);
    #1;
    chk("cont_ready_b", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 3'b000;
    chk("cont_reg_b", 32'(bus.wr_reg), 32'h3);
    chk("cont_data_b", bus.wr_data, 32'hC3);
`endif

    // stall for 3 cycles with requester 1 pending
    bus.wr_stall  = 1'b1;
    bus.req_valid = 3'b010;
    set_req(1, 5'd7, 32'h77);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", 32'(bus.req_ready), 32'h0);
      tick();
      chk("stall_wr_en", 32'(bus.wr_en), 32'h1);
`ifdef WB_ARB_RR_EN
      chk("stall_wr_reg", 32'(bus.wr_reg), 32'h1);
`else
      chk("stall_wr_reg", 32'(bus.wr_reg), 32'h3);
`endif
    end
    bus.wr_stall = 1'b0;
    #1;
    chk("unstall_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 3'b000;
    chk("unstall_wr_en", 32'(bus.wr_en), 32'h1);
    chk("unstall_wr_reg", 32'(bus.wr_reg), 32'h7);
    chk("unstall_wr_data", bus.wr_data, 32'h77);
    tick();
    chk("drain_wr_en", 32'(bus.wr_en), 32'h0);

    // all three continuously valid after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 5'd10, 32'hA0);
    set_req(1, 5'd11, 32'hB0);
    set_req(2, 5'd12, 32'hC0);
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin
        bus.wr_stall = 1'b1;
        #1;
        chk("all_stall_ready", 32'(bus.req_ready), 32'h0);
        tick();
        bus.wr_stall = 1'b0;
      end
`ifdef WB_ARB_RR_EN
      exp_g = 3'b001 << (k % 3);
`else
      exp_g = 3'b001;
`endif
      #1;
      chk("all_ready", 32'(bus.req_ready), 32'(exp_g));
      tick();
      chk("all_wr_reg", 32'(bus.wr_reg), 32'(exp_g == 3'b001 ? 10 : exp_g == 3'b010 ? 11 : 12));
    end

    // reset while a write sits in the output register
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 32'h55);
    tick();
    chk("mid_wr_en_pre", 32'(bus.wr_en), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("mid_wr_en", 32'(bus.wr_en), 32'h0);
    chk("mid_wr_reg", 32'(bus.wr_reg), 32'h0);
    rst = 1'b0;
    bus.req_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
